// File: rtl/receiver_pkg.sv
// Shared widths and the loader state encoding for the receive path.
package receiver_pkg;

    localparam int WORD_W   = 16;
    localparam int SAMPLE_W = 32;
    localparam int ADDR_W   = 16;

    typedef enum logic [1:0] {
        ST_ACCEPT    = 2'd0,
        ST_WRITE_Q   = 2'd1,
        ST_FULL_WAIT = 2'd2
    } loader_state_e;

endpackage

// File: rtl/sample_loader.sv
// Ping-pong frame loader: splits I/Q samples into two word writes into buffer A or B.
// state        | meaning
// ST_ACCEPT    | in_ready high, next sample is written to the current buffer
// ST_WRITE_Q   | I word on the bus this cycle, Q word goes out next
// ST_FULL_WAIT | target buffer still owned by the DSP, waiting for frame_ack
module sample_loader
    import receiver_pkg::*;
#(
    parameter int unsigned           FRAME_LEN = 256,
    parameter logic [ADDR_W-1:0]     BASE_A    = 16'h0000,
    parameter logic [ADDR_W-1:0]     BASE_B    = BASE_A + ADDR_W'(2 * FRAME_LEN)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [SAMPLE_W-1:0]   in_data,
    output logic                  in_ready,
    output logic [ADDR_W-1:0]     write_addr,
    output logic [WORD_W-1:0]     write_data,
    output logic                  write_en,
    output logic                  frame_done,
    output logic [ADDR_W-1:0]     frame_base,
    input  logic                  frame_ack,
    output logic [1:0]            frames_pending,
    output logic                  ack_err
);

    localparam int KW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);

    loader_state_e        state_q, state_d;
    logic                 cur_q, cur_d;
    logic [KW-1:0]        k_q, k_d;
    logic [WORD_W-1:0]    q_word_q, q_word_d;
    logic                 write_en_q, write_en_d;
    logic [ADDR_W-1:0]    write_addr_q, write_addr_d;
    logic [WORD_W-1:0]    write_data_q, write_data_d;
    logic                 frame_done_q, frame_done_d;
    logic [ADDR_W-1:0]    frame_base_q, frame_base_d;
    logic                 done_buf_q, done_buf_d;
    logic                 pend_a_q, pend_a_d;
    logic                 pend_b_q, pend_b_d;
    logic                 oldest_q, oldest_d;
    logic                 ack_err_q, ack_err_d;

    logic                 any_pend;
    logic                 ack_rel;
    logic                 ack_takes_new;
    logic                 rel_a, rel_b;
    logic                 set_a, set_b;
    logic                 other_busy;
    logic                 target_free;
    logic [ADDR_W-1:0]    base_cur;

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        k_d           = k_q;
        q_word_d      = q_word_q;
        write_en_d    = 1'b0;
        write_addr_d  = write_addr_q;
        write_data_d  = write_data_q;
        frame_done_d  = 1'b0;
        frame_base_d  = frame_base_q;
        done_buf_d    = done_buf_q;

        base_cur = cur_q ? BASE_B : BASE_A;

        // A completed frame becomes pending the cycle frame_done is visible, so an
        // ack arriving with frame_done releases the oldest frame while the new one lands.
        any_pend      = pend_a_q | pend_b_q;
        ack_rel       = frame_ack & any_pend;
        ack_takes_new = frame_ack & ~any_pend & frame_done_q;
        ack_err_d     = ack_err_q | (frame_ack & ~any_pend & ~frame_done_q);
        rel_a         = ack_rel & ~oldest_q;
        rel_b         = ack_rel & oldest_q;
        set_a         = frame_done_q & ~done_buf_q & ~ack_takes_new;
        set_b         = frame_done_q & done_buf_q & ~ack_takes_new;
        pend_a_d      = (pend_a_q & ~rel_a) | set_a;
        pend_b_d      = (pend_b_q & ~rel_b) | set_b;
        oldest_d      = (pend_a_d & pend_b_d) ? oldest_q : pend_b_d;

        other_busy  = cur_q ? pend_a_d : pend_b_d;
        target_free = cur_q ? ~pend_b_d : ~pend_a_d;

        case (state_q)
            ST_ACCEPT: begin
                if (in_valid) begin
                    write_en_d   = 1'b1;
                    write_addr_d = base_cur + (ADDR_W'(k_q) << 1);
                    write_data_d = in_data[SAMPLE_W-1:WORD_W];
                    q_word_d     = in_data[WORD_W-1:0];
                    state_d      = ST_WRITE_Q;
                end
            end
            ST_WRITE_Q: begin
                write_en_d   = 1'b1;
                write_addr_d = write_addr_q + ADDR_W'(1);
                write_data_d = q_word_q;
                if (k_q == K_LAST) begin
                    frame_done_d = 1'b1;
                    frame_base_d = base_cur;
                    done_buf_d   = cur_q;
                    cur_d        = ~cur_q;
                    k_d          = '0;
                    state_d      = other_busy ? ST_FULL_WAIT : ST_ACCEPT;
                end else begin
                    k_d     = k_q + KW'(1);
                    state_d = ST_ACCEPT;
                end
            end
            ST_FULL_WAIT: begin
                if (target_free) begin
                    state_d = ST_ACCEPT;
                end
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_ACCEPT;
            cur_q        <= 1'b0;
            k_q          <= '0;
            q_word_q     <= '0;
            write_en_q   <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            frame_done_q <= 1'b0;
            frame_base_q <= BASE_A;
            done_buf_q   <= 1'b0;
            pend_a_q     <= 1'b0;
            pend_b_q     <= 1'b0;
            oldest_q     <= 1'b0;
            ack_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cur_q        <= cur_d;
            k_q          <= k_d;
            q_word_q     <= q_word_d;
            write_en_q   <= write_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            frame_done_q <= frame_done_d;
            frame_base_q <= frame_base_d;
            done_buf_q   <= done_buf_d;
            pend_a_q     <= pend_a_d;
            pend_b_q     <= pend_b_d;
            oldest_q     <= oldest_d;
            ack_err_q    <= ack_err_d;
        end
    end

    assign in_ready       = (state_q == ST_ACCEPT);
    assign write_en       = write_en_q;
    assign write_addr     = write_addr_q;
    assign write_data     = write_data_q;
    assign frame_done     = frame_done_q;
    assign frame_base     = frame_base_q;
    assign frames_pending = {1'b0, pend_a_q} + {1'b0, pend_b_q};
    assign ack_err        = ack_err_q;

endmodule

// File: tb/tb_sample_loader.sv
// Directed bench for sample_loader with FRAME_LEN=4, BASE_A=0, BASE_B=8.
module tb_sample_loader;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic [15:0] write_addr;
    logic [15:0] write_data;
    logic        write_en;
    logic        frame_done;
    logic [15:0] frame_base;
    logic        frame_ack;
    logic [1:0]  frames_pending;
    logic        ack_err;

    int checks = 0;
    int errors = 0;

    sample_loader #(
        .FRAME_LEN (4),
        .BASE_A    (16'h0000),
        .BASE_B    (16'h0008)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_data        (in_data),
        .in_ready       (in_ready),
        .write_addr     (write_addr),
        .write_data     (write_data),
        .write_en       (write_en),
        .frame_done     (frame_done),
        .frame_base     (frame_base),
        .frame_ack      (frame_ack),
        .frames_pending (frames_pending),
        .ack_err        (ack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        frame_ack = 1'b0;
        in_data   = 32'h0;
        rst_n     = 1'b0;
        cycle();
        cycle();
        rst_n = 1'b1;
    endtask

    // One sample: I write next cycle, Q write the cycle after; rdy_exp < 0 skips the ready check.
    task automatic push(input logic [15:0] iw, input logic [15:0] qw, input int addr,
                        input bit last_exp, input int base_exp, input int rdy_exp);
        in_valid = 1'b1;
        in_data  = {iw, qw};
        cycle();
        chk("i_en",   write_en,   1);
        chk("i_addr", write_addr, addr);
        chk("i_data", write_data, iw);
        chk("busy",   in_ready,   0);
        in_data  = 32'hDEADBEEF;
        in_valid = 1'b0;
        cycle();
        chk("q_en",   write_en,   1);
        chk("q_addr", write_addr, addr + 1);
        chk("q_data", write_data, qw);
        chk("done",   frame_done, last_exp);
        if (last_exp) chk("base", frame_base, base_exp);
        if (rdy_exp >= 0) chk("rdy_after", in_ready, rdy_exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'h0;
        frame_ack = 1'b0;
        #3;
        chk("rst_we",    write_en,       0);
        chk("rst_addr",  write_addr,     0);
        chk("rst_data",  write_data,     0);
        chk("rst_done",  frame_done,     0);
        chk("rst_base",  frame_base,     0);
        chk("rst_pend",  frames_pending, 0);
        chk("rst_err",   ack_err,        0);

        // single sample
        do_reset();
        chk("first_rdy", in_ready, 1);
        push(16'hAAAA, 16'h5555, 0, 1'b0, 0, 1);
        cycle();
        chk("idle_we", write_en, 0);
        chk("one_pend", frames_pending, 0);

        // one full frame back to back
        do_reset();
        for (int i = 0; i < 4; i++)
            push(16'h1000 + 16'(i), 16'h2000 + 16'(i), 2 * i, i == 3, 0, 1);
        cycle();
        chk("f1_pend", frames_pending, 1);
        chk("f1_done_low", frame_done, 0);
        chk("f1_base_hold", frame_base, 0);

        // two frames without ack, ninth held off
        do_reset();
        for (int i = 0; i < 8; i++)
            push(16'h3000 + 16'(i), 16'h4000 + 16'(i), 2 * i, (i == 3) || (i == 7),
                 (i < 4) ? 0 : 8, (i == 7) ? 0 : 1);
        cycle();
        chk("f2_pend", frames_pending, 2);
        chk("f2_base", frame_base, 8);
        in_valid = 1'b1;
        in_data  = 32'h9999_6666;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("hold_rdy", in_ready, 0);
            chk("hold_we",  write_en, 0);
        end
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        chk("rel_rdy",  in_ready, 1);
        chk("rel_pend", frames_pending, 1);
        cycle();
        chk("s9_en",   write_en,   1);
        chk("s9_addr", write_addr, 0);
        chk("s9_data", write_data, 16'h9999);
        in_valid = 1'b0;
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        chk("s9_q_addr", write_addr, 1);
        chk("s9_q_data", write_data, 16'h6666);
        chk("fifo_pend", frames_pending, 0);
        chk("no_err",    ack_err, 0);

        // ack coincident with second frame_done
        do_reset();
        for (int i = 0; i < 8; i++)
            push(16'h5000 + 16'(i), 16'h6000 + 16'(i), 2 * i, (i == 3) || (i == 7),
                 (i < 4) ? 0 : 8, (i == 7) ? -1 : 1);
        chk("co_pend_before", frames_pending, 1);
        frame_ack = 1'b1;
        in_valid  = 1'b1;
        in_data   = 32'h7777_8888;
        cycle();
        frame_ack = 1'b0;
        chk("co_pend", frames_pending, 1);
        chk("co_rdy",  in_ready, 1);
        cycle();
        in_valid = 1'b0;
        chk("co_addr", write_addr, 0);
        chk("co_data", write_data, 16'h7777);
        cycle();
        chk("co_q_addr", write_addr, 1);

        // spurious ack
        do_reset();
        frame_ack = 1'b1;
        cycle();
        frame_ack = 1'b0;
        chk("err_set",  ack_err, 1);
        chk("err_pend", frames_pending, 0);
        cycle();
        chk("err_sticky", ack_err, 1);

        // reset mid-frame
        do_reset();
        chk("err_clr", ack_err, 0);
        push(16'hA000, 16'hB000, 0, 1'b0, 0, 1);
        push(16'hA001, 16'hB001, 2, 1'b0, 0, 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_we", write_en, 0);
        cycle();
        rst_n = 1'b1;
        push(16'hC000, 16'hD000, 0, 1'b0, 0, 1);
        push(16'hC001, 16'hD001, 2, 1'b0, 0, 1);
        cycle();
        chk("mid_no_done", frame_done, 0);
        chk("mid_pend",    frames_pending, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sample_loader.md
SAMPLE_LOADER -- requirements
Module: sample_loader

Interface
REQ-001 Parameter FRAME_LEN, default 256: samples per frame, power of two, range 2..16384.
REQ-002 Parameter BASE_A, default 16'h0000: first word address of buffer A in data memory bank I.
REQ-003 Parameter BASE_B, default BASE_A + 2*FRAME_LEN: first word address of buffer B; the A and B regions SHALL NOT overlap.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 in_valid  input  1  in_data holds a sample.
REQ-007 in_data  input  32  sample; [31:16] = I word, [15:0] = Q word.
REQ-008 in_ready  output  1  loader accepts the sample this cycle.
REQ-009 write_addr  output  16  data memory bank I write address.
REQ-010 write_data  output  16  data memory bank I write data.
REQ-011 write_en  output  1  write strobe to data memory bank I.
REQ-012 frame_done  output  1  one-cycle pulse: a full frame is in memory.
REQ-013 frame_base  output  16  base address of the most recently completed frame.
REQ-014 frame_ack  input  1  one-cycle pulse from DSP: oldest pending frame consumed.
REQ-015 frames_pending  output  2  count of completed, unacknowledged frames (0..2).
REQ-016 ack_err  output  1  sticky flag: frame_ack received while frames_pending = 0.

Function
REQ-017 A sample SHALL be accepted in any cycle where in_valid = 1 and in_ready = 1.
REQ-018 FSM states SHALL be ACCEPT, WRITE_Q and FULL_WAIT; in_ready = 1 only in ACCEPT.
REQ-019 For a sample accepted in cycle N, index k of the current buffer, base B: cycle N+1 SHALL drive write_en = 1, write_addr = B+2k, write_data = I word.
REQ-020 For the same sample, cycle N+2 SHALL drive write_en = 1, write_addr = B+2k+1, write_data = Q word; the FSM is in WRITE_Q during cycle N+1.
REQ-021 write_addr, write_data and write_en SHALL be registered outputs; write_en = 0 in every cycle without a write.
REQ-022 Peak throughput SHALL be one sample per two cycles; the Q word SHALL be captured at acceptance and held stable regardless of later in_data changes.
REQ-023 In the cycle the Q word of sample FRAME_LEN-1 is written, frame_done SHALL pulse for one cycle.
REQ-024 In that same cycle, frame_base SHALL update to the completed buffer's base address and hold until the next frame_done.
REQ-025 On frame completion the loader SHALL switch to the other buffer at k = 0.
REQ-026 If the other buffer is pending, the FSM SHALL enter FULL_WAIT; otherwise it SHALL enter ACCEPT.
REQ-027 frame_ack SHALL release the oldest pending buffer, giving first-in, first-out release order.
REQ-028 In FULL_WAIT, a frame_ack that frees the target buffer SHALL make in_ready = 1 on the next cycle.
REQ-029 If frame_ack and frame completion coincide in one cycle, both SHALL take effect and frames_pending SHALL be unchanged.
REQ-030 A frame_ack while frames_pending = 0 SHALL be ignored and SHALL set ack_err; ack_err clears only on reset.
REQ-031 Buffer selection SHALL alternate A, B, A, B, ... without exception.

Reset
REQ-032 Reset SHALL force: FSM = ACCEPT, current buffer = A, k = 0, frames_pending = 0.
REQ-033 Reset SHALL force outputs: write_en = 0, write_addr = 0, write_data = 0, frame_done = 0, frame_base = BASE_A, ack_err = 0.
REQ-034 After reset release, in_ready SHALL be 1 in the first clock cycle.
REQ-035 Reset mid-frame SHALL discard the partial frame with no frame_done pulse and no further writes.

Structure
REQ-036 Package receiver_pkg SHALL hold WORD_W = 16, SAMPLE_W = 32, ADDR_W = 16 and the loader state enum.
REQ-037 The block SHALL be a single module with no sub-module; buffer-ownership tracking is two flags plus an oldest pointer.

Verification (FRAME_LEN = 4, BASE_A = 0, BASE_B = 8)
REQ-038 Single sample 32'hAAAA5555 after reset -> writes (0, AAAA) then (1, 5555) on consecutive cycles; in_ready low for exactly one cycle.
REQ-039 Four back-to-back samples -> 8 writes to addr 0..7; frame_done pulses with the addr-7 write; frame_base = 0; frames_pending = 1.
REQ-040 Eight samples, no ack -> second frame_done with frame_base = 8 and frames_pending = 2; ninth sample held off, in_ready = 0 until frame_ack, then write to addr 0.
REQ-041 frame_ack coincident with the second frame_done -> frames_pending stays 1; no stall on the ninth sample.
REQ-042 frame_ack while frames_pending = 0 -> ack_err = 1; frames_pending stays 0.
REQ-043 rst_n asserted after 2 samples -> no frame_done; the next sample writes addr 0.
